// File: rtl/id_pkg.sv
// Shared decode definitions for the 16-bit pipeline ID stage: opcodes, field positions,
// immediate helpers and the ID/EX payload.
package id_pkg;

  localparam int unsigned XLEN = 16;
  localparam int unsigned OPW  = 4;
  localparam int unsigned RAW  = 4;

  localparam logic [OPW-1:0] OP_NOP  = 4'h0;
  localparam logic [OPW-1:0] OP_ADD  = 4'h1;
  localparam logic [OPW-1:0] OP_SUB  = 4'h2;
  localparam logic [OPW-1:0] OP_AND  = 4'h3;
  localparam logic [OPW-1:0] OP_OR   = 4'h4;
  localparam logic [OPW-1:0] OP_ADDI = 4'h5;
  localparam logic [OPW-1:0] OP_LDI  = 4'h6;
  localparam logic [OPW-1:0] OP_LD   = 4'h7;
  localparam logic [OPW-1:0] OP_ST   = 4'h8;
  localparam logic [OPW-1:0] OP_BEQ  = 4'h9;
  localparam logic [OPW-1:0] OP_JMP  = 4'hA;

  localparam int unsigned OP_MSB = 15;
  localparam int unsigned OP_LSB = 12;
  localparam int unsigned RD_MSB = 11;
  localparam int unsigned RD_LSB = 8;
  localparam int unsigned RS_MSB = 7;
  localparam int unsigned RS_LSB = 4;
  localparam int unsigned RT_MSB = 3;
  localparam int unsigned RT_LSB = 0;

  localparam logic [XLEN-1:0] NOP_INSTR = 16'h0000;

  typedef struct packed {
    logic            valid;
    logic [OPW-1:0]  op;
    logic [RAW-1:0]  rd;
    logic [XLEN-1:0] a;
    logic [XLEN-1:0] b;
    logic [XLEN-1:0] imm;
    logic            we;
    logic [XLEN-1:0] pc;
  } idex_t;

  function automatic logic [XLEN-1:0] sext_imm4(input logic [3:0] v);
    return {{(XLEN-4){v[3]}}, v};
  endfunction

  function automatic logic [XLEN-1:0] sext_off12(input logic [11:0] v);
    return {{(XLEN-12){v[11]}}, v};
  endfunction

  function automatic logic [XLEN-1:0] zext_imm8(input logic [7:0] v);
    return {{(XLEN-8){1'b0}}, v};
  endfunction

endpackage

// File: rtl/id_regfile.sv
// 16x16 register file: r0 hard-wired to zero, one write port, three combinational read
// ports (rs, rt/store-data, rd-compare) each bypassing the same-cycle write-back.
module id_regfile
  import id_pkg::*;
#(
  parameter int unsigned NREGS = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [RAW-1:0]  ra_a_i,
  input  logic [RAW-1:0]  ra_b_i,
  input  logic [RAW-1:0]  ra_c_i,
  output logic [XLEN-1:0] rdata_a_c_o,
  output logic [XLEN-1:0] rdata_b_c_o,
  output logic [XLEN-1:0] rdata_c_c_o,
  input  logic            we_i,
  input  logic [RAW-1:0]  waddr_i,
  input  logic [XLEN-1:0] wdata_i
);

  logic [XLEN-1:0] regs_q [NREGS];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < NREGS; i++) begin
        regs_q[i] <= '0;
      end
    end else if (we_i && (waddr_i != '0)) begin
      regs_q[waddr_i] <= wdata_i;
    end
  end

  // r0 forcing takes priority over bypass so a WB to r0 never leaks through.
  assign rdata_a_c_o = (ra_a_i == '0) ? '0 :
                       (we_i && (waddr_i == ra_a_i)) ? wdata_i : regs_q[ra_a_i];
  assign rdata_b_c_o = (ra_b_i == '0) ? '0 :
                       (we_i && (waddr_i == ra_b_i)) ? wdata_i : regs_q[ra_b_i];
  assign rdata_c_c_o = (ra_c_i == '0) ? '0 :
                       (we_i && (waddr_i == ra_c_i)) ? wdata_i : regs_q[ra_c_i];

endmodule

// File: rtl/id_stage.sv
// Decode stage: IF/ID register, decode, operand read, jump/branch resolution, ID/EX register.
// Build option ILLEGAL_TRAP_EN redirects valid illegal opcodes to TRAP_VEC.
module id_stage
  import id_pkg::*;
#(
  parameter int unsigned     NREGS    = 16,
  parameter logic [XLEN-1:0] TRAP_VEC = 16'h00F0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [XLEN-1:0] instr_IF,
  input  logic [XLEN-1:0] PC,
  output logic            jump,
  output logic [XLEN-1:0] PC_jump,
  input  logic            wb_we,
  input  logic [RAW-1:0]  wb_addr,
  input  logic [XLEN-1:0] wb_data,
  output logic            ex_valid,
  output logic [OPW-1:0]  ex_op,
  output logic [RAW-1:0]  ex_rd,
  output logic [XLEN-1:0] ex_a,
  output logic [XLEN-1:0] ex_b,
  output logic [XLEN-1:0] ex_imm,
  output logic            ex_we,
  output logic [XLEN-1:0] ex_PC,
  output logic            illegal
);

  logic [XLEN-1:0] ifid_instr_q, ifid_instr_d;
  logic [XLEN-1:0] ifid_pc_q, ifid_pc_d;
  logic            ifid_valid_q, ifid_valid_d;
  idex_t           idex_q, idex_d;
  logic            illegal_q, illegal_d;

  logic [OPW-1:0]  op_c;
  logic [RAW-1:0]  rd_c, rs_c, rt_c, rb_addr_c;
  logic [XLEN-1:0] rs_val_c, rb_val_c, rd_val_c;
  logic            illegal_op_c, jmp_c, beq_taken_c, trap_c;

  assign op_c = ifid_instr_q[OP_MSB:OP_LSB];
  assign rd_c = ifid_instr_q[RD_MSB:RD_LSB];
  assign rs_c = ifid_instr_q[RS_MSB:RS_LSB];
  assign rt_c = ifid_instr_q[RT_MSB:RT_LSB];

  // ST carries its store data in the rd field, so port B follows rd for stores.
  assign rb_addr_c = (op_c == OP_ST) ? rd_c : rt_c;

  id_regfile #(
    .NREGS(NREGS)
  ) u_regfile (
    .clk         (clk),
    .rst         (rst),
    .ra_a_i      (rs_c),
    .ra_b_i      (rb_addr_c),
    .ra_c_i      (rd_c),
    .rdata_a_c_o (rs_val_c),
    .rdata_b_c_o (rb_val_c),
    .rdata_c_c_o (rd_val_c),
    .we_i        (wb_we),
    .waddr_i     (wb_addr),
    .wdata_i     (wb_data)
  );

  assign illegal_op_c = (op_c > OP_JMP);
  assign jmp_c        = ifid_valid_q && (op_c == OP_JMP);
  assign beq_taken_c  = ifid_valid_q && (op_c == OP_BEQ) && (rd_val_c == rs_val_c);

`ifdef ILLEGAL_TRAP_EN
  assign trap_c = ifid_valid_q && illegal_op_c;
`else
  assign trap_c = 1'b0;
`endif

  assign jump = jmp_c || beq_taken_c || trap_c;

  // Redirect target; wraps modulo 2^16.
  always_comb begin
    PC_jump = '0;
    if (trap_c) begin
      PC_jump = TRAP_VEC;
    end else if (jmp_c) begin
      PC_jump = XLEN'(ifid_pc_q + sext_off12(ifid_instr_q[11:0]));
    end else if (beq_taken_c) begin
      PC_jump = XLEN'(ifid_pc_q + sext_imm4(ifid_instr_q[3:0]));
    end
  end

  // A redirect squashes the sequential fetch currently arriving from IF.
  always_comb begin
    ifid_instr_d = instr_IF;
    ifid_pc_d    = PC;
    ifid_valid_d = 1'b1;
    if (jump) begin
      ifid_instr_d = NOP_INSTR;
      ifid_pc_d    = '0;
      ifid_valid_d = 1'b0;
    end
  end

  always_comb begin
    idex_d    = '0;
    illegal_d = illegal_q;
    if (ifid_valid_q) begin
      idex_d.pc = ifid_pc_q;
      if (illegal_op_c) begin
        illegal_d    = 1'b1;
        idex_d.valid = !trap_c;
      end else begin
        idex_d.valid = 1'b1;
        idex_d.op    = op_c;
        idex_d.rd    = rd_c;
        idex_d.a     = rs_val_c;
        idex_d.b     = rb_val_c;
        idex_d.we    = (op_c >= OP_ADD) && (op_c <= OP_LD) && (rd_c != '0);
        case (op_c)
          OP_LDI:  idex_d.imm = zext_imm8(ifid_instr_q[7:0]);
          OP_JMP:  idex_d.imm = sext_off12(ifid_instr_q[11:0]);
          default: idex_d.imm = sext_imm4(ifid_instr_q[3:0]);
        endcase
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ifid_instr_q <= NOP_INSTR;
      ifid_pc_q    <= '0;
      ifid_valid_q <= 1'b0;
      idex_q       <= '0;
      illegal_q    <= 1'b0;
    end else begin
      ifid_instr_q <= ifid_instr_d;
      ifid_pc_q    <= ifid_pc_d;
      ifid_valid_q <= ifid_valid_d;
      idex_q       <= idex_d;
      illegal_q    <= illegal_d;
    end
  end

  assign ex_valid = idex_q.valid;
  assign ex_op    = idex_q.op;
  assign ex_rd    = idex_q.rd;
  assign ex_a     = idex_q.a;
  assign ex_b     = idex_q.b;
  assign ex_imm   = idex_q.imm;
  assign ex_we    = idex_q.we;
  assign ex_PC    = idex_q.pc;
  assign illegal  = illegal_q;

endmodule

// File: tb/tb_id_stage.sv
// Self-checking bench for id_stage: directed cases then randomized traffic against a
// reference model of the decode stage. Define ILLEGAL_TRAP_EN to match a trap build.
module tb_id_stage;

  localparam logic [15:0] TRAP_PC = 16'h00F0;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] instr_IF, PC, PC_jump, wb_data, ex_a, ex_b, ex_imm, ex_PC;
  logic        jump, wb_we, ex_valid, ex_we, illegal;
  logic [3:0]  wb_addr, ex_op, ex_rd;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state
  logic [15:0] m_reg [16];
  logic [15:0] m_if_instr, m_if_pc;
  logic        m_if_valid;
  logic        m_ex_valid, m_ex_we, m_illegal;
  logic [3:0]  m_ex_op, m_ex_rd;
  logic [15:0] m_ex_a, m_ex_b, m_ex_imm, m_ex_pc;
  logic        exp_jump, last_jump;
  logic [15:0] exp_pcj, last_pcj;

  always #5 clk = ~clk;

  id_stage dut (
    .clk(clk), .rst(rst), .instr_IF(instr_IF), .PC(PC), .jump(jump), .PC_jump(PC_jump),
    .wb_we(wb_we), .wb_addr(wb_addr), .wb_data(wb_data), .ex_valid(ex_valid),
    .ex_op(ex_op), .ex_rd(ex_rd), .ex_a(ex_a), .ex_b(ex_b), .ex_imm(ex_imm),
    .ex_we(ex_we), .ex_PC(ex_PC), .illegal(illegal)
  );

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic int sx(input int v, input int bits);
    return (v >= (1 << (bits - 1))) ? v - (1 << bits) : v;
  endfunction

  // Architectural read as ID sees it: r0 is zero, a same-cycle write-back wins.
  function automatic logic [15:0] mread(input int a);
    if (a == 0) return 16'h0;
    if (wb_we && int'(wb_addr) == a) return wb_data;
    return m_reg[a];
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 16; i++) m_reg[i] = 16'h0;
    m_if_instr = 16'h0; m_if_pc = 16'h0; m_if_valid = 1'b0;
    m_ex_valid = 1'b0; m_ex_we = 1'b0; m_ex_op = 4'h0; m_ex_rd = 4'h0;
    m_ex_a = 16'h0; m_ex_b = 16'h0; m_ex_imm = 16'h0; m_ex_pc = 16'h0;
    m_illegal = 1'b0;
  endtask

  task automatic model_redirect();
    int op, rd, rs;
    op = int'(m_if_instr[15:12]);
    rd = int'(m_if_instr[11:8]);
    rs = int'(m_if_instr[7:4]);
    exp_jump = 1'b0;
    exp_pcj  = 16'h0;
    if (m_if_valid) begin
      if (op == 10) begin
        exp_jump = 1'b1;
        exp_pcj  = 16'(int'(m_if_pc) + sx(int'(m_if_instr[11:0]), 12));
      end else if (op == 9 && mread(rd) == mread(rs)) begin
        exp_jump = 1'b1;
        exp_pcj  = 16'(int'(m_if_pc) + sx(int'(m_if_instr[3:0]), 4));
      end
`ifdef ILLEGAL_TRAP_EN
      else if (op > 10) begin
        exp_jump = 1'b1;
        exp_pcj  = TRAP_PC;
      end
`endif
    end
  endtask

  task automatic model_edge(input logic [15:0] ins, input logic [15:0] pc);
    int op, rd, rs, rt;
    op = int'(m_if_instr[15:12]);
    rd = int'(m_if_instr[11:8]);
    rs = int'(m_if_instr[7:4]);
    rt = int'(m_if_instr[3:0]);
    m_ex_valid = 1'b0; m_ex_we = 1'b0; m_ex_op = 4'h0; m_ex_rd = 4'h0;
    m_ex_a = 16'h0; m_ex_b = 16'h0; m_ex_imm = 16'h0; m_ex_pc = 16'h0;
    if (m_if_valid) begin
      if (op > 10) begin
        m_illegal = 1'b1;
`ifndef ILLEGAL_TRAP_EN
        m_ex_valid = 1'b1;
        m_ex_pc    = m_if_pc;
`endif
      end else begin
        m_ex_valid = 1'b1;
        m_ex_op    = 4'(op);
        m_ex_rd    = 4'(rd);
        m_ex_a     = mread(rs);
        m_ex_b     = (op == 8) ? mread(rd) : mread(rt);
        m_ex_imm   = (op == 6) ? 16'(int'(m_if_instr[7:0])) :
                     (op == 10) ? 16'(sx(int'(m_if_instr[11:0]), 12)) : 16'(sx(rt, 4));
        m_ex_we    = (op >= 1 && op <= 7 && rd != 0);
        m_ex_pc    = m_if_pc;
      end
    end
    if (exp_jump) begin
      m_if_instr = 16'h0; m_if_pc = 16'h0; m_if_valid = 1'b0;
    end else begin
      m_if_instr = ins; m_if_pc = pc; m_if_valid = 1'b1;
    end
    if (wb_we && wb_addr != 4'h0) m_reg[wb_addr] = wb_data;
  endtask

  task automatic check_ex();
    int op;
    op = int'(m_ex_op);
    check("ex_valid", 16'(ex_valid), 16'(m_ex_valid));
    check("ex_op", 16'(ex_op), 16'(m_ex_op));
    check("ex_we", 16'(ex_we), 16'(m_ex_we));
    check("illegal", 16'(illegal), 16'(m_illegal));
    if (m_ex_valid) begin
      check("ex_pc", ex_PC, m_ex_pc);
      if (op >= 1 && op <= 9) check("ex_rd", 16'(ex_rd), 16'(m_ex_rd));
      if ((op >= 1 && op <= 5) || (op >= 7 && op <= 9)) check("ex_a", ex_a, m_ex_a);
      if ((op >= 1 && op <= 4) || op == 8) check("ex_b", ex_b, m_ex_b);
      if (op >= 5 && op <= 10) check("ex_imm", ex_imm, m_ex_imm);
    end
  endtask

  // One cycle: drive IF and WB, check the redirect, clock, check the ID/EX bundle.
  task automatic step(input logic [15:0] ins, input logic [15:0] pc, input logic we,
                      input logic [3:0] wa, input logic [15:0] wd);
    instr_IF = ins; PC = pc; wb_we = we; wb_addr = wa; wb_data = wd;
    #1;
    model_redirect();
    last_jump = jump;
    last_pcj  = PC_jump;
    check("jump", 16'(jump), 16'(exp_jump));
    if (exp_jump) check("pc_jump", PC_jump, exp_pcj);
    @(posedge clk);
    model_edge(ins, pc);
    #1;
    check_ex();
  endtask

  task automatic check_all_zero(input string pfx);
    check({pfx, "_jump"}, 16'(jump), 16'h0);
    check({pfx, "_pc_jump"}, PC_jump, 16'h0);
    check({pfx, "_ex_valid"}, 16'(ex_valid), 16'h0);
    check({pfx, "_ex_op"}, 16'(ex_op), 16'h0);
    check({pfx, "_ex_rd"}, 16'(ex_rd), 16'h0);
    check({pfx, "_ex_a"}, ex_a, 16'h0);
    check({pfx, "_ex_b"}, ex_b, 16'h0);
    check({pfx, "_ex_imm"}, ex_imm, 16'h0);
    check({pfx, "_ex_we"}, 16'(ex_we), 16'h0);
    check({pfx, "_ex_pc"}, ex_PC, 16'h0);
    check({pfx, "_illegal"}, 16'(illegal), 16'h0);
  endtask

  initial begin
    logic [15:0] pc;
    logic [15:0] ins;
    int r, op;

    rst = 1'b1; instr_IF = 16'h0; PC = 16'h0; wb_we = 1'b0; wb_addr = 4'h0; wb_data = 16'h0;
    model_reset();
    #12;
    check_all_zero("rst");
    rst = 1'b0;

    // LDI r1,5 at PC 0 appears on ex_* two edges after fetch
    step(16'h6105, 16'h0000, 1'b0, 4'h0, 16'h0);
    check("ldi_first_slot_invalid", 16'(ex_valid), 16'h0);
    step(16'h0000, 16'h0001, 1'b0, 4'h0, 16'h0);
    check("ldi_valid", 16'(ex_valid), 16'h1);
    check("ldi_op", 16'(ex_op), 16'h6);
    check("ldi_rd", 16'(ex_rd), 16'h1);
    check("ldi_imm", ex_imm, 16'h0005);
    check("ldi_we", 16'(ex_we), 16'h1);
    check("ldi_pc", ex_PC, 16'h0000);

    // ADD r3,r2,r0 reads r2 through the write-back bypass
    step(16'h1320, 16'h0002, 1'b0, 4'h0, 16'h0);
    step(16'h0000, 16'h0003, 1'b1, 4'h2, 16'h1234);
    check("add_bypass_a", ex_a, 16'h1234);
    check("add_b_r0", ex_b, 16'h0000);

    // JMP -2 at PC 1 wraps to FFFF and squashes the next fetch
    step(16'hAFFE, 16'h0001, 1'b0, 4'h0, 16'h0);
    step(16'h0000, 16'h0002, 1'b0, 4'h0, 16'h0);
    check("jmp_jump", 16'(last_jump), 16'h1);
    check("jmp_wrap_target", last_pcj, 16'hFFFF);
    step(16'h0000, 16'hFFFF, 1'b0, 4'h0, 16'h0);
    check("jmp_squash_valid", 16'(ex_valid), 16'h0);

    // BEQ r4,r5,+3 at PC 0x10: taken when equal, falls through otherwise
    step(16'h0000, 16'h0004, 1'b1, 4'h4, 16'h0007);
    step(16'h0000, 16'h0005, 1'b1, 4'h5, 16'h0007);
    step(16'h9453, 16'h0010, 1'b0, 4'h0, 16'h0);
    step(16'h0000, 16'h0011, 1'b0, 4'h0, 16'h0);
    check("beq_taken", 16'(last_jump), 16'h1);
    check("beq_target", last_pcj, 16'h0013);
    step(16'h0000, 16'h0013, 1'b1, 4'h5, 16'h0008);
    step(16'h9453, 16'h0010, 1'b0, 4'h0, 16'h0);
    step(16'h0000, 16'h0011, 1'b0, 4'h0, 16'h0);
    check("beq_not_taken", 16'(last_jump), 16'h0);
    step(16'h0000, 16'h0012, 1'b0, 4'h0, 16'h0);
    check("beq_no_bubble", 16'(ex_valid), 16'h1);

    // Illegal opcode
    step(16'hF000, 16'h0020, 1'b0, 4'h0, 16'h0);
    step(16'h0000, 16'h0021, 1'b0, 4'h0, 16'h0);
    check("ill_flag", 16'(illegal), 16'h1);
    check("ill_we", 16'(ex_we), 16'h0);
`ifdef ILLEGAL_TRAP_EN
    check("ill_trap_jump", 16'(last_jump), 16'h1);
    check("ill_trap_target", last_pcj, TRAP_PC);
    check("ill_trap_valid", 16'(ex_valid), 16'h0);
`else
    check("ill_no_jump", 16'(last_jump), 16'h0);
    check("ill_nop_valid", 16'(ex_valid), 16'h1);
`endif

    // Reset asserted while a taken JMP sits in IF/ID
    step(16'hAFFE, 16'h0005, 1'b0, 4'h0, 16'h0);
    #1;
    check("pre_rst_jump", 16'(jump), 16'h1);
    rst = 1'b1;
    #1;
    check_all_zero("midrst");
    model_reset();
    @(negedge clk);
    #1;
    rst = 1'b0;
    step(16'h6207, 16'h0030, 1'b0, 4'h0, 16'h0);
    check("post_rst_first_invalid", 16'(ex_valid), 16'h0);

    // Randomized traffic; the fetch PC follows the model's redirect decisions
    pc = 16'h0100;
    for (int i = 0; i < 400; i++) begin
      r = $urandom_range(0, 99);
      if (r < 5) op = 0;
      else if (r < 9) op = 11 + $urandom_range(0, 4);
      else op = 1 + $urandom_range(0, 9);
      ins = {4'(op), 12'($urandom)};
      if (op == 9 && $urandom_range(0, 2) == 0) ins[7:4] = ins[11:8];
      step(ins, pc, 1'($urandom_range(0, 1)), 4'($urandom), 16'($urandom));
      pc = exp_jump ? exp_pcj : 16'(pc + 16'h1);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
